// File: rtl/mem_stage_lsu_if.sv
// Bundle of EX/MEM inputs, the stall output and the MEM/WB register outputs of mem_stage_lsu.
// master drives the M-stage side; slave is the load/store unit itself.
interface mem_stage_lsu_if #(
   parameter int XLEN = 32
);
   logic            RegWriteM;
   logic [1:0]      ResultSrcM;
   logic            MemWriteM;
   logic            MemReadM;
   logic [2:0]      Funct3M;
   logic [XLEN-1:0] ALUResultM;
   logic [XLEN-1:0] WriteDataM;
   logic [4:0]      RdM;
   logic [XLEN-1:0] PCPlus4M;

   logic            StallM;
   logic            RegWriteW;
   logic [1:0]      ResultSrcW;
   logic [XLEN-1:0] ALUResultW;
   logic [XLEN-1:0] ReadDataW;
   logic [4:0]      RdW;
   logic [XLEN-1:0] PCPlus4W;
   logic            MisalignW;

   modport master (
      output RegWriteM, ResultSrcM, MemWriteM, MemReadM, Funct3M,
             ALUResultM, WriteDataM, RdM, PCPlus4M,
      input  StallM, RegWriteW, ResultSrcW, ALUResultW, ReadDataW,
             RdW, PCPlus4W, MisalignW
   );

   modport slave (
      input  RegWriteM, ResultSrcM, MemWriteM, MemReadM, Funct3M,
             ALUResultM, WriteDataM, RdM, PCPlus4M,
      output StallM, RegWriteW, ResultSrcW, ALUResultW, ReadDataW,
             RdW, PCPlus4W, MisalignW
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage: byte/half/word load-store unit, LATENCY-cycle data array and MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input logic          CLK,
   input logic          RST,
   mem_stage_lsu_if.slave bus
);
   localparam int AW       = $clog2(DEPTH_WORDS);
   localparam int CW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next;
   logic            stall;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   logic            is_mem, is_store, is_load, misalign, access, sgn;
   size_t           size;
   logic [AW-1:0]   idx;
   logic [1:0]      lane;
   logic [3:0]      be;
   logic [XLEN-1:0] wdata, rword, rdata;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic            unused_addr;

   assign idx         = bus.ALUResultM[AW+1:2];
   assign lane        = bus.ALUResultM[1:0];
   assign unused_addr = ^bus.ALUResultM[XLEN-1:AW+2];

   // Stores and loads decode the size field differently (store 100 is a word).
   always_comb begin
      is_mem   = bus.MemReadM | bus.MemWriteM;
      is_store = bus.MemWriteM;
      is_load  = bus.MemReadM & ~bus.MemWriteM;
      if (is_store)
         size = (bus.Funct3M == 3'b000) ? SZ_BYTE :
                (bus.Funct3M == 3'b001) ? SZ_HALF : SZ_WORD;
      else
         size = (bus.Funct3M[1:0] == 2'b00) ? SZ_BYTE :
                (bus.Funct3M[1:0] == 2'b01) ? SZ_HALF : SZ_WORD;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign = is_mem & (((size == SZ_HALF) & lane[0]) |
                           ((size == SZ_WORD) & (lane != 2'b00)));
`else
      misalign = 1'b0;
`endif
      access = is_mem & ~misalign;
   end

   always_comb begin
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wdata = {4{bus.WriteDataM[7:0]}};
         end
         SZ_HALF: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{bus.WriteDataM[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = bus.WriteDataM;
         end
      endcase
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rword  = mem[idx];
      sgn    = ~bus.Funct3M[2];
      byte_v = rword[{lane, 3'b000} +: 8];
      half_v = lane[1] ? rword[31:16] : rword[15:0];
      rdata  = '0;
      if (is_load && !misalign) begin
         case (size)
            SZ_BYTE: rdata = {{24{sgn & byte_v[7]}}, byte_v};
            SZ_HALF: rdata = {{16{sgn & half_v[15]}}, half_v};
            default: rdata = rword;
         endcase
      end
   end

   // NOTE: the data array has no reset; only the write is gated, by RST and by stall.
   always_ff @(posedge CLK) begin
      if (!RST && !stall && access && is_store) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (access && (LATENCY > 1)) begin
               stall      = 1'b1;
               state_next = BUSY;
               cnt_next   = CW'(CNT_INIT);
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               stall    = 1'b1;
               cnt_next = cnt - CW'(1);
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.StallM = stall;

   // Stalled cycles insert a bubble: write-enable and trap flag drop, payload holds.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.RegWriteW  <= 1'b0;
         bus.ResultSrcW <= '0;
         bus.ALUResultW <= '0;
         bus.ReadDataW  <= '0;
         bus.RdW        <= '0;
         bus.PCPlus4W   <= '0;
         bus.MisalignW  <= 1'b0;
      end else if (stall) begin
         bus.RegWriteW  <= 1'b0;
         bus.MisalignW  <= 1'b0;
      end else begin
         bus.RegWriteW  <= bus.RegWriteM & ~misalign;
         bus.ResultSrcW <= bus.ResultSrcM;
         bus.ALUResultW <= bus.ALUResultM;
         bus.ReadDataW  <= rdata;
         bus.RdW        <= bus.RdM;
         bus.PCPlus4W   <= bus.PCPlus4M;
         bus.MisalignW  <= misalign;
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: LATENCY=1 and LATENCY=3 instances against a byte-addressed model.
// Expectations follow MEM_MISALIGN_TRAP_EN when the bench is built with it defined.
module tb_mem_stage_lsu;
   localparam int DEPTH  = 1024;
   localparam int ABYTES = DEPTH * 4;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_lsu_if #(.XLEN(32)) bus1 ();
   mem_stage_lsu_if #(.XLEN(32)) bus3 ();

   mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .CLK(clk), .RST(rst), .bus(bus1.slave));
   mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
      .CLK(clk), .RST(rst), .bus(bus3.slave));

   typedef struct packed {
      logic        rw, mr, mw;
      logic [1:0]  rs;
      logic [2:0]  f3;
      logic [31:0] addr, wd, pc;
      logic [4:0]  rd;
   } op_t;

   typedef struct packed {
      logic        stall, rw;
      logic [1:0]  rs;
      logic [31:0] alu, rdata, pc;
      logic [4:0]  rd;
      logic        mis;
   } wout_t;

   int checks = 0;
   int errors = 0;
   logic [7:0] ref_mem [2][ABYTES];
   op_t nop = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input op_t o);
      if (d == 0) begin
         bus1.RegWriteM = o.rw;  bus1.MemReadM = o.mr;  bus1.MemWriteM = o.mw;
         bus1.ResultSrcM = o.rs; bus1.Funct3M = o.f3;   bus1.ALUResultM = o.addr;
         bus1.WriteDataM = o.wd; bus1.PCPlus4M = o.pc;  bus1.RdM = o.rd;
      end else begin
         bus3.RegWriteM = o.rw;  bus3.MemReadM = o.mr;  bus3.MemWriteM = o.mw;
         bus3.ResultSrcM = o.rs; bus3.Funct3M = o.f3;   bus3.ALUResultM = o.addr;
         bus3.WriteDataM = o.wd; bus3.PCPlus4M = o.pc;  bus3.RdM = o.rd;
      end
   endtask

   function automatic wout_t sample(input int d);
      wout_t w;
      if (d == 0)
         w = '{bus1.StallM, bus1.RegWriteW, bus1.ResultSrcW, bus1.ALUResultW,
               bus1.ReadDataW, bus1.PCPlus4W, bus1.RdW, bus1.MisalignW};
      else
         w = '{bus3.StallM, bus3.RegWriteW, bus3.ResultSrcW, bus3.ALUResultW,
               bus3.ReadDataW, bus3.PCPlus4W, bus3.RdW, bus3.MisalignW};
      return w;
   endfunction

   function automatic op_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd);
      op_t o;
      o.rw = mr; o.mr = mr; o.mw = mw; o.rs = mr ? 2'b01 : 2'b00;
      o.f3 = f3; o.addr = addr; o.wd = wd; o.pc = $urandom;
      o.rd = 5'($urandom_range(1, 31));
      return o;
   endfunction

   // Access size in bytes; stores and loads read the size field differently.
   function automatic int acc_size(input op_t o);
      if (o.mw) return (o.f3 == 3'b000) ? 1 : (o.f3 == 3'b001) ? 2 : 4;
      return (o.f3[1:0] == 2'b00) ? 1 : (o.f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_mis(input op_t o);
      int unsigned a = o.addr % ABYTES;
      return TRAP && (o.mr || o.mw) && ((a % acc_size(o)) != 0);
   endfunction

   // Apply one op at posedge+1, follow it to completion, compare W outputs with the model.
   task automatic run_op(input int d, input op_t o);
      int          lat    = (d == 0) ? 1 : 3;
      int          sz     = acc_size(o);
      bit          mis    = is_mis(o);
      bit          mem    = o.mr | o.mw;
      int unsigned base   = ((o.addr % ABYTES) / sz) * sz;
      int          stalls = 0;
      logic [31:0] exp_rd = '0;
      string       p      = (d == 0) ? "L1" : "L3";
      wout_t       w;

      if (o.mr && !o.mw && !mis) begin
         for (int i = 0; i < sz; i++) exp_rd[8*i +: 8] = ref_mem[d][base + i];
         if (sz < 4 && !o.f3[2] && exp_rd[8*sz-1])
            for (int i = sz; i < 4; i++) exp_rd[8*i +: 8] = 8'hFF;
      end
      if (o.mw && !mis)
         for (int i = 0; i < sz; i++) ref_mem[d][base + i] = o.wd[8*i +: 8];

      drive(d, o);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         w = sample(d);
         if (!w.stall) break;
         if (c > 0) begin
            check({p, "_bubble_rw"},  32'(w.rw),  32'd0);
            check({p, "_bubble_mis"}, 32'(w.mis), 32'd0);
         end
         stalls++;
         @(posedge clk); #1;
      end
      check({p, "_stalls"}, 32'(stalls), (mem && !mis) ? 32'(lat - 1) : 32'd0);
      @(posedge clk); #1;
      w = sample(d);
      check({p, "_rw"},    32'(w.rw),  32'(o.rw & ~mis));
      check({p, "_rs"},    32'(w.rs),  32'(o.rs));
      check({p, "_alu"},   w.alu,      o.addr);
      check({p, "_rdata"}, w.rdata,    exp_rd);
      check({p, "_rd"},    32'(w.rd),  32'(o.rd));
      check({p, "_pc"},    w.pc,       o.pc);
      check({p, "_mis"},   32'(w.mis), 32'(mis));
      drive(d, nop);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      wout_t w;
      op_t   o;
      int    kind;

      drive(0, nop);
      drive(1, nop);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         w = sample(d);
         check("reset_w", 32'({w.stall, w.rw, w.rs, w.rd, w.mis}), 32'd0);
         check("reset_alu", w.alu ^ w.rdata ^ w.pc, 32'd0);
         check("reset_rdata", w.rdata, 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Give the region used below defined contents in both arrays.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++)
            run_op(d, mk(1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom));

      run_op(0, mk(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF));
      run_op(0, mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0));
      check("t1_lw", sample(0).rdata, 32'hDEADBEEF);

      run_op(0, mk(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080));
      run_op(0, mk(1'b1, 1'b0, 3'b000, 32'h13, 32'h0));
      check("t2_lb", sample(0).rdata, 32'hFFFFFF80);
      run_op(0, mk(1'b1, 1'b0, 3'b100, 32'h13, 32'h0));
      check("t2_lbu", sample(0).rdata, 32'h00000080);
      run_op(0, mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0));
      check("t2_lw", sample(0).rdata, 32'h80ADBEEF);

      run_op(1, mk(1'b0, 1'b1, 3'b010, 32'h10, 32'hA5A50F0F));
      run_op(1, mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0));
      check("t3_lw", sample(1).rdata, 32'hA5A50F0F);

      // Store aborted by reset during its second stall cycle.
      run_op(1, mk(1'b0, 1'b1, 3'b010, 32'h24, 32'h01020304));
      drive(1, mk(1'b0, 1'b1, 3'b010, 32'h24, 32'hFFFFFFFF));
      @(posedge clk); #1;
      check("t4_stall2", 32'(bus3.StallM), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1, nop);
      @(negedge clk);
      w = sample(1);
      check("t4_w_ctrl", 32'({w.stall, w.rw, w.rs, w.rd, w.mis}), 32'd0);
      check("t4_w_alu", w.alu, 32'd0);
      check("t4_w_rdata", w.rdata, 32'd0);
      check("t4_w_pc", w.pc, 32'd0);
      @(posedge clk); #1;
      run_op(1, mk(1'b1, 1'b0, 3'b010, 32'h24, 32'h0));
      check("t4_unchanged", sample(1).rdata, 32'h01020304);

      run_op(0, mk(1'b0, 1'b1, 3'b010, 32'h1000, 32'h5A5A1234));
      run_op(0, mk(1'b1, 1'b0, 3'b010, 32'h0000, 32'h0));
      check("t5_alias", sample(0).rdata, 32'h5A5A1234);

      run_op(0, mk(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344));
      o = mk(1'b0, 1'b1, 3'b001, 32'h21, 32'h0000ABCD);
      o.rw = 1'b1;
      run_op(0, o);
      check("t6_mis", 32'(sample(0).mis), TRAP ? 32'd1 : 32'd0);
      check("t6_rw", 32'(sample(0).rw), TRAP ? 32'd0 : 32'd1);
      run_op(0, mk(1'b1, 1'b0, 3'b010, 32'h20, 32'h0));
      check("t6_word", sample(0).rdata, TRAP ? 32'h11223344 : 32'h1122ABCD);

      // Random mix over the initialised 64-byte window with random aliasing bits.
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 7);
            o = mk(kind inside {[2:4]} || kind == 7, kind inside {[5:7]}, 3'($urandom),
                   ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);
            o.rw = 1'($urandom);
            o.rs = 2'($urandom_range(0, 2));
            run_op(d, o);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
